pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register. Generalises the ID/EX latch to any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with arbitrary payload width.
- Adds an explicit valid bit, bubble insertion on stall, and a deferred-flush (squash-next) mechanism for branch redirects that arrive while the upstream stage is stalled.
- Sits between two pipeline stages. It is driven by the global stall bus from the stall controller and by the branch/flush signal from EX.

Parameters:
- DATA_W, 110, payload width in bits (aluop, alusel, reg1, reg2, wd, wreg, pc, offset concatenated by the instantiator).
- STALL_W, 6, width of the global stall bus.
- STAGE, 2, index of the upstream stage's stall bit; bit STAGE+1 is the downstream stage's bit. Legal range is 0..STALL_W-2.
- NOP_DATA, {DATA_W{1'b0}}, payload value driven on a bubble or flush.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  STALL_W  global stall bus; 1 = stage stopped.
- flush_i  in  1  branch/jump taken in EX this cycle; squash wrong-path work.
- in_valid  in  1  upstream slot holds a real instruction.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  registered valid to the downstream stage.
- out_data  out  DATA_W  registered payload to the downstream stage.
- flush_pending_o  out  1  deferred flush armed; the next advancing entry will be squashed.

Behaviour:
- Definitions:
  - up_stop = stall[STAGE]
  - dn_stop = stall[STAGE+1]
  - advance = !up_stop
  - bubble = up_stop & !dn_stop
  - hold = up_stop & dn_stop
- Reset (rst=1 at a clock edge): out_valid=0, out_data=NOP_DATA, flush_pending=0. Reset mid-stall or mid-flush overrides everything.
- Priority per edge: rst > flush_i > bubble > hold > advance. There is a single-cycle latency from in_* to out_*.
- flush_i=1:
  - Drive out_valid=0 and out_data=NOP_DATA regardless of stall, including while holding.
  - If up_stop=1, set flush_pending=1: the stalled upstream entry is wrong-path and will arrive later.
  - If up_stop=0, clear flush_pending; the current input is squashed this edge.
- bubble (flush_i=0): out_valid=0, out_data=NOP_DATA; flush_pending unchanged.
- hold (flush_i=0): out_valid, out_data and flush_pending all retain their values.
- advance (flush_i=0):
  - If flush_pending=1: output a bubble (out_valid=0, out_data=NOP_DATA) and clear flush_pending. The entry is squashed even if in_valid=1.
  - Otherwise: out_valid=in_valid. out_data=in_data if in_valid=1, else NOP_DATA.
- flush_pending is a 2-state FSM (IDLE, ARMED):
  - IDLE->ARMED on flush_i & up_stop.
  - ARMED->IDLE on an advance edge, or on flush_i & !up_stop.
  - A repeated flush while ARMED stays ARMED; no counting.
- flush_pending_o equals the ARMED state and is registered.
- An X-free output is required: out_data never passes through in_data when the captured valid is 0.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- When defined, adds outputs stat_bubbles and stat_squashes, each 32 bits, zeroed on rst, saturating at 32'hFFFFFFFF.
  - stat_bubbles increments on every edge that writes out_valid=0 due to the bubble rule.
  - stat_squashes increments on every edge that discards in_valid=1 due to flush_i or flush_pending.
- When not defined, these ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Reset, then pass-through: rst=1 for 2 cycles, then stall=0, in_valid=1, in_data=0x…1234 for 3 cycles. Required: out_valid=0/out_data=0 during reset; out_data=0x…1234 with out_valid=1 one cycle after the first input.
- Bubble: stall=6'b000100 (STAGE=2) with in_valid=1. Required: out_valid=0, out_data=NOP_DATA next edge; with stall=6'b001100, out holds the previous valid payload.
- Immediate flush: stall=0, flush_i=1, in_valid=1, in_data=0xAA. Required: out_valid=0 and flush_pending_o=0 next edge.
- Deferred flush:
  - flush_i=1 with stall=6'b000100. Required: out bubble and flush_pending_o=1.
  - Then stall=0, in_data=0xBB, in_valid=1. Required: out_valid=0 and flush_pending_o=0.
  - Following input 0xCC. Required: out_data=0xCC, out_valid=1.
- Flush during hold: stall=6'b001100, out holds 0x55, flush_i=1. Required: out_valid=0, flush_pending_o=1; the held payload is discarded.
- Reset mid-deferred-flush: ARMED state, then rst=1 for 1 cycle. Required: flush_pending_o=0. First advance afterwards passes in_data unsquashed. With PIPE_STAGE_STATS_EN, counters read 0 after reset.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline stage boundary register (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   It carries a valid bit next to an opaque payload. When the upstream stage
//   stalls and downstream does not, it inserts a bubble. A branch redirect that
//   arrives while upstream is stalled is remembered as a deferred flush, so
//   the next entry that advances is squashed.
//
//   Optional build macro: PIPE_STAGE_STATS_EN
//     When defined, adds saturating 32-bit bubble/squash event counters.
//
// Ports
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset
//   stall[STALL_W]  in   global stall bus; bit STAGE = upstream, STAGE+1 = downstream
//   flush_i         in   redirect taken in EX; squash wrong-path work
//   in_valid        in   upstream slot holds a real instruction
//   in_data[DATA_W] in   upstream payload
//   out_valid       out  registered valid to downstream
//   out_data        out  registered payload to downstream (NOP_DATA when invalid)
//   flush_pending_o out  deferred flush armed
//   stat_bubbles    out  (PIPE_STAGE_STATS_EN) bubble insertions
//   stat_squashes   out  (PIPE_STAGE_STATS_EN) valid entries discarded by flush
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                DATA_W   = 110,
  parameter int                STALL_W  = 6,
  parameter int                STAGE    = 2,
  parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush_i,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
`ifdef PIPE_STAGE_STATS_EN
  output logic [31:0]        stat_bubbles,
  output logic [31:0]        stat_squashes,
`endif
  output logic               flush_pending_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  // Only two bits of the stall bus matter here; the rest is folded into a
  // sink so the remaining bus bits do not look like forgotten wiring.
  logic unused_stall;
  assign unused_stall = ^stall;

  logic up_stop, dn_stop, advance, bubble, hold;
  assign up_stop = stall[STAGE];
  assign dn_stop = stall[STAGE+1];
  assign advance = !up_stop;
  assign bubble  = up_stop & !dn_stop;
  assign hold    = up_stop & dn_stop;

  logic [0:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              ev_bubble, ev_squash;

  // Next-state selection follows flush > bubble > hold > advance.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    data_d    = data_q;
    ev_bubble = 1'b0;
    ev_squash = 1'b0;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = NOP_DATA;
      // A stalled upstream entry is wrong-path but has not been consumed yet,
      // so squash it when it finally advances.
      state_d   = up_stop ? ARMED : IDLE;
      ev_squash = advance & in_valid;
    end else if (bubble) begin
      valid_d   = 1'b0;
      data_d    = NOP_DATA;
      ev_bubble = 1'b1;
    end else if (hold) begin
      state_d = state_q;
    end else if (state_q == ARMED) begin
      valid_d   = 1'b0;
      data_d    = NOP_DATA;
      state_d   = IDLE;
      ev_squash = in_valid;
    end else begin
      valid_d = in_valid;
      // Never let in_data through under an invalid slot; keeps out_data X-free.
      data_d  = in_valid ? in_data : NOP_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= NOP_DATA;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_data        = data_q;
  assign flush_pending_o = (state_q == ARMED);

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] bub_q, sq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bub_q <= '0;
      sq_q  <= '0;
    end else begin
      if (ev_bubble && bub_q != 32'hFFFF_FFFF) bub_q <= bub_q + 32'd1;
      if (ev_squash && sq_q  != 32'hFFFF_FFFF) sq_q  <= sq_q  + 32'd1;
    end
  end

  assign stat_bubbles  = bub_q;
  assign stat_squashes = sq_q;
`else
  logic unused_ev;
  assign unused_ev = ev_bubble ^ ev_squash;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int DW = 110;
  localparam int SW = 6;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] stall;
  logic          flush_i;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          flush_pending_o;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]   stat_bubbles, stat_squashes;
`endif

  pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE(ST)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush_i(flush_i),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
`ifdef PIPE_STAGE_STATS_EN
    .stat_bubbles(stat_bubbles), .stat_squashes(stat_squashes),
`endif
    .flush_pending_o(flush_pending_o)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Reference model: what the downstream stage should see, per the stage rules.
  logic          m_v, m_p;
  logic [DW-1:0] m_d;
  longint        m_b, m_s;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [SW-1:0] s, input logic f,
                       input logic v, input logic [DW-1:0] d);
    logic up, dn;
    rst = r; stall = s; flush_i = f; in_valid = v; in_data = d;
    up = s[ST]; dn = s[ST+1];
    if (r) begin
      m_v = 1'b0; m_d = '0; m_p = 1'b0; m_b = 0; m_s = 0;
    end else if (f) begin
      if (!up && v) m_s++;
      m_v = 1'b0; m_d = '0; m_p = up;
    end else if (up && !dn) begin
      m_v = 1'b0; m_d = '0; m_b++;
    end else if (up) begin
      // stage held: nothing changes
    end else if (m_p) begin
      if (v) m_s++;
      m_v = 1'b0; m_d = '0; m_p = 1'b0;
    end else begin
      m_v = v; m_d = v ? d : '0;
    end
    @(posedge clk); #1;
    chk1("out_valid", out_valid, m_v);
    chkd("out_data", out_data, m_d);
    chk1("flush_pending", flush_pending_o, m_p);
`ifdef PIPE_STAGE_STATS_EN
    chkd("stat_bubbles", {{(DW-32){1'b0}}, stat_bubbles}, DW'(m_b > 64'hFFFFFFFF ? 64'hFFFFFFFF : m_b));
    chkd("stat_squashes", {{(DW-32){1'b0}}, stat_squashes}, DW'(m_s > 64'hFFFFFFFF ? 64'hFFFFFFFF : m_s));
`endif
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[DW-1:0];
  endfunction

  initial begin
    m_v = 1'b0; m_d = '0; m_p = 1'b0; m_b = 0; m_s = 0;

    // reset then pass-through
    drive(1, 6'b0, 0, 0, '0);
    drive(1, 6'b0, 0, 1, DW'('h1234));
    drive(0, 6'b0, 0, 1, DW'('h1234));
    chkd("pass_data", out_data, DW'('h1234));
    chk1("pass_valid", out_valid, 1'b1);
    drive(0, 6'b0, 0, 1, DW'('h1234));
    drive(0, 6'b0, 0, 1, DW'('h1234));

    // bubble, then hold of a valid payload
    drive(0, 6'b000100, 0, 1, DW'('h777));
    chk1("bubble_valid", out_valid, 1'b0);
    drive(0, 6'b000000, 0, 1, DW'('h55));
    drive(0, 6'b001100, 0, 1, DW'('h66));
    chkd("hold_data", out_data, DW'('h55));

    // flush during hold discards the held payload and arms
    drive(0, 6'b001100, 1, 1, DW'('h66));
    chk1("hold_flush_pend", flush_pending_o, 1'b1);
    drive(0, 6'b000000, 0, 1, DW'('h99));

    // immediate flush
    drive(0, 6'b000000, 1, 1, DW'('hAA));
    chk1("imm_flush_pend", flush_pending_o, 1'b0);

    // deferred flush
    drive(0, 6'b000100, 1, 1, DW'('hBB));
    chk1("def_pend", flush_pending_o, 1'b1);
    drive(0, 6'b000000, 0, 1, DW'('hBB));
    chk1("def_squash", out_valid, 1'b0);
    drive(0, 6'b000000, 0, 1, DW'('hCC));
    chkd("def_after", out_data, DW'('hCC));

    // reset while armed
    drive(0, 6'b000100, 1, 1, DW'('h11));
    drive(1, 6'b000100, 0, 1, DW'('h11));
    chk1("rst_pend", flush_pending_o, 1'b0);
    drive(0, 6'b000000, 0, 1, DW'('hDD));
    chkd("rst_after", out_data, DW'('hDD));

    // invalid input yields NOP payload even with garbage data
    drive(0, 6'b000000, 0, 0, rnd_data());
    chkd("inv_nop", out_data, '0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [SW-1:0] s;
      s = SW'($urandom);
      drive(($urandom_range(0, 49) == 0), s, ($urandom_range(0, 4) == 0),
            1'($urandom), rnd_data());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
